// File: rtl/cnn_layer_sequencer_pkg.sv
// Shared types and per-layer pass schedule for the CNN layer sequencer.
// Table index is the layer: CONV2, CONV4, FC6, FC7.
package cnn_seq_pkg;

  typedef enum logic [1:0] {
    L_CONV2 = 2'd0,
    L_CONV4 = 2'd1,
    L_FC6   = 2'd2,
    L_FC7   = 2'd3
  } layer_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONV2,
    S_CONV4,
    S_FC6,
    S_FC7,
    S_WAIT_DIGIT,
    S_DONE
  } state_e;

  localparam logic [3:0]  P         [4] = '{4'd1, 4'd8, 4'd4, 4'd1};
  localparam logic [10:0] WT_BASE   [4] = '{11'd0, 11'd9, 11'd1161, 11'd1737};
  localparam logic [10:0] WT_STRIDE [4] = '{11'd9, 11'd144, 11'd144, 11'd0};
  localparam logic [3:0]  BI_BASE   [4] = '{4'd0, 4'd1, 4'd9, 4'd13};

  function automatic logic [10:0] pass_wt_base(layer_e l, logic [3:0] idx);
    return WT_BASE[l] + 11'(idx) * WT_STRIDE[l];
  endfunction

  function automatic logic [3:0] pass_bi_base(layer_e l, logic [3:0] idx);
    return BI_BASE[l] + idx;
  endfunction

endpackage

// File: rtl/cnn_layer_sequencer_tracker.sv
// Per-layer pass bookkeeping: passes issued, passes in flight at the receiver,
// sender-idle flag, and the permission to issue the next pass.
module seq_pass_tracker #(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       issue,
  input  logic       snd_done,
  input  logic       rcv_done,
  input  logic [3:0] passes,
  output logic       issue_ok,
  output logic [3:0] issued,
  output logic       drained,
  output logic       proto_err
);

  logic [1:0] outstanding;
  logic       sender_idle;
  logic       rcv_ok;
  logic [1:0] out_eff;
  logic       idle_eff;

  // Same-cycle completions count toward issue permission, so a new pass can
  // start on the edge that retires the previous one.
  assign rcv_ok    = rcv_done && (outstanding != 2'd0);
  assign out_eff   = outstanding - 2'(rcv_ok);
  assign idle_eff  = sender_idle || snd_done;
  assign issue_ok  = idle_eff && (issued < passes) && (int'(out_eff) < MAX_OUTSTANDING);
  assign drained   = (issued == passes) && (outstanding == 2'd0) && sender_idle;
  assign proto_err = (rcv_done && (outstanding == 2'd0)) || (snd_done && sender_idle);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issued      <= 4'd0;
      outstanding <= 2'd0;
      sender_idle <= 1'b1;
    end else if (clr) begin
      issued      <= 4'd0;
      outstanding <= 2'd0;
      sender_idle <= 1'b1;
    end else begin
      if (issue) issued <= issued + 4'd1;
      if (issue && !rcv_ok)      outstanding <= outstanding + 2'd1;
      else if (!issue && rcv_ok) outstanding <= outstanding - 2'd1;
      if (issue)         sender_idle <= 1'b0;
      else if (snd_done) sender_idle <= 1'b1;
    end
  end

endmodule

// File: rtl/cnn_layer_sequencer.sv
// Steps one image through CONV2 -> CONV4 -> FC6 -> FC7, issuing sender passes
// with bounded run-ahead, draining between layers, and guarding with a watchdog.
module cnn_layer_sequencer
  import cnn_seq_pkg::*;
#(
  parameter int IMG_PIXELS      = 784,
  parameter int MAX_OUTSTANDING = 2,
  parameter int TIMEOUT         = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pixel_i_valid,
  output logic        pixel_i_ready,
  output logic [1:0]  layer_id,
  output logic        pass_start,
  output logic [3:0]  pass_idx,
  output logic [10:0] wt_base,
  output logic [3:0]  bi_base,
  input  logic        snd_done,
  input  logic        rcv_done,
  input  logic        digit_o_valid,
  output logic        busy,
  output logic [15:0] img_cnt,
  output logic        err
);

  localparam int PIX_W = $clog2(IMG_PIXELS + 1);
  localparam int WD_W  = $clog2(TIMEOUT + 1);
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(IMG_PIXELS);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);

  state_e           state, next_state, state_d;
  layer_e           cur_layer;
  logic             run_q;
  logic [PIX_W-1:0] pix_cnt;
  logic [WD_W-1:0]  wd_cnt;
  logic             beat, layer_active, layer_exit;
  logic             wd_evt, wd_expire, issue_now;
  logic             issue_ok, drained, proto_err;
  logic [3:0]       issued;

  function automatic layer_e state_layer(state_e s);
    case (s)
      S_CONV4:                     return L_CONV4;
      S_FC6:                       return L_FC6;
      S_FC7, S_WAIT_DIGIT, S_DONE: return L_FC7;
      default:                     return L_CONV2;
    endcase
  endfunction

  assign cur_layer     = state_layer(state);
  assign layer_id      = cur_layer;
  assign busy          = (state != S_IDLE);
  assign layer_active  = (state == S_CONV2) || (state == S_CONV4) ||
                         (state == S_FC6)   || (state == S_FC7);
  // run_q keeps intake closed while reset is held and for the first edge after.
  assign pixel_i_ready = run_q && ((state == S_IDLE) ||
                                   ((state == S_CONV2) && (pix_cnt < PIX_LAST)));
  assign beat          = pixel_i_valid && pixel_i_ready;

  always_comb begin
    next_state = state;
    layer_exit = 1'b0;
    case (state)
      S_IDLE:       if (beat) next_state = S_CONV2;
      S_CONV2:      if (drained && (pix_cnt == PIX_LAST)) begin
                      next_state = S_CONV4;
                      layer_exit = 1'b1;
                    end
      S_CONV4:      if (drained) begin next_state = S_FC6;        layer_exit = 1'b1; end
      S_FC6:        if (drained) begin next_state = S_FC7;        layer_exit = 1'b1; end
      S_FC7:        if (drained) begin next_state = S_WAIT_DIGIT; layer_exit = 1'b1; end
      S_WAIT_DIGIT: if (digit_o_valid) next_state = S_DONE;
      S_DONE:       next_state = S_IDLE;
      default:      next_state = S_IDLE;
    endcase
  end

  assign wd_evt    = beat || snd_done || rcv_done || (next_state != state);
  assign wd_expire = busy && !wd_evt && (wd_cnt == WD_LAST);
  assign state_d   = wd_expire ? S_IDLE : next_state;
  // The first pixel beat launches the single CONV2 pass on the same edge.
  assign issue_now = !wd_expire && (((state == S_IDLE) && beat) || (layer_active && issue_ok));

  seq_pass_tracker #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_tracker (
    .clk       (clk),
    .rst       (rst),
    .clr       (layer_exit || wd_expire),
    .issue     (issue_now),
    .snd_done  (snd_done),
    .rcv_done  (rcv_done),
    .passes    (P[cur_layer]),
    .issue_ok  (issue_ok),
    .issued    (issued),
    .drained   (drained),
    .proto_err (proto_err)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q      <= 1'b0;
      pix_cnt    <= '0;
      wd_cnt     <= '0;
      pass_start <= 1'b0;
      pass_idx   <= 4'd0;
      wt_base    <= 11'd0;
      bi_base    <= 4'd0;
      img_cnt    <= 16'd0;
      err        <= 1'b0;
    end else begin
      run_q      <= 1'b1;
      pass_start <= issue_now;
      if (issue_now) begin
        pass_idx <= issued;
        wt_base  <= pass_wt_base(cur_layer, issued);
        bi_base  <= pass_bi_base(cur_layer, issued);
      end else if (layer_exit) begin
        pass_idx <= 4'd0;
      end
      if (wd_expire || (state == S_DONE)) pix_cnt <= '0;
      else if (beat)                      pix_cnt <= pix_cnt + 1'b1;
      if (!busy || wd_evt || wd_expire) wd_cnt <= '0;
      else                              wd_cnt <= wd_cnt + 1'b1;
      if ((state == S_WAIT_DIGIT) && digit_o_valid) img_cnt <= img_cnt + 16'd1;
      if (wd_expire || proto_err) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Directed bench for cnn_layer_sequencer with a simple sender/receiver model.
module tb_cnn_layer_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        pixel_i_valid;
  logic        pixel_i_ready;
  logic [1:0]  layer_id;
  logic        pass_start;
  logic [3:0]  pass_idx;
  logic [10:0] wt_base;
  logic [3:0]  bi_base;
  logic        snd_done, rcv_done;
  logic        digit_o_valid;
  logic        busy;
  logic [15:0] img_cnt;
  logic        err;

  logic auto_en, slow_mode, m_snd, m_rcv, t_snd, t_rcv, sl;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   snd_timer;
  int   slow_rcv_cyc;
  int   rcv_q[$];
  logic slow_q[$];

  typedef struct {
    logic [1:0]  lid;
    logic [3:0]  idx;
    logic [10:0] wt;
    logic [3:0]  bi;
    int          c;
  } ps_t;
  ps_t log_q[$];

  int exp_lid [14] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 2, 2, 2, 2, 3};
  int exp_idx [14] = '{0, 0, 1, 2, 3, 4, 5, 6, 7, 0, 1, 2, 3, 0};
  int exp_wt  [14] = '{0, 9, 153, 297, 441, 585, 729, 873, 1017, 1161, 1305, 1449, 1593, 1737};
  int exp_bi  [14] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13};

  assign snd_done = auto_en ? m_snd : t_snd;
  assign rcv_done = auto_en ? m_rcv : t_rcv;

  cnn_layer_sequencer #(
    .IMG_PIXELS      (784),
    .MAX_OUTSTANDING (2),
    .TIMEOUT         (100)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pixel_i_valid (pixel_i_valid),
    .pixel_i_ready (pixel_i_ready),
    .layer_id      (layer_id),
    .pass_start    (pass_start),
    .pass_idx      (pass_idx),
    .wt_base       (wt_base),
    .bi_base       (bi_base),
    .snd_done      (snd_done),
    .rcv_done      (rcv_done),
    .digit_o_valid (digit_o_valid),
    .busy          (busy),
    .img_cnt       (img_cnt),
    .err           (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst === 1'b1 && pass_start === 1'b1)
      log_q.push_back('{lid: layer_id, idx: pass_idx, wt: wt_base, bi: bi_base, c: cyc});
  end

  // Sender finishes 20 cycles after pass_start; receiver 20 cycles after that
  // (50 for FC6 pass 3 when slow_mode is set).
  always @(negedge clk) begin
    if (!auto_en || rst !== 1'b1) begin
      m_snd = 1'b0; m_rcv = 1'b0; snd_timer = 0;
      rcv_q.delete(); slow_q.delete();
    end else begin
      m_snd = 1'b0; m_rcv = 1'b0;
      if (snd_timer > 0) begin
        snd_timer--;
        if (snd_timer == 0) begin
          m_snd = 1'b1;
          sl = slow_mode && (layer_id == 2'd2) && (pass_idx == 4'd3);
          rcv_q.push_back(cyc + (sl ? 50 : 20));
          slow_q.push_back(sl);
        end
      end
      if (pass_start) snd_timer = 20;
      if (rcv_q.size() > 0 && rcv_q[0] <= cyc) begin
        m_rcv = 1'b1;
        if (slow_q[0]) slow_rcv_cyc = cyc;
        void'(rcv_q.pop_front());
        void'(slow_q.pop_front());
      end
    end
  end

  task automatic do_reset();
    rst = 1'b0; pixel_i_valid = 1'b0; digit_o_valid = 1'b0;
    t_snd = 1'b0; t_rcv = 1'b0; auto_en = 1'b0; slow_mode = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    log_q.delete();
  endtask

  task automatic feed(input int n);
    pixel_i_valid = 1'b1;
    repeat (n) @(negedge clk);
    pixel_i_valid = 1'b0;
  endtask

  task automatic pulse(input logic s, input logic r);
    t_snd = s; t_rcv = r;
    @(negedge clk);
    t_snd = 1'b0; t_rcv = 1'b0;
  endtask

  task automatic wait_pass(input int budget, output logic got);
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (pass_start) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; pixel_i_valid = 1'b0; digit_o_valid = 1'b0;
    t_snd = 1'b0; t_rcv = 1'b0; auto_en = 1'b0; slow_mode = 1'b0; slow_rcv_cyc = 0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({pixel_i_ready, layer_id, pass_start, pass_idx, wt_base, bi_base, busy, img_cnt, err} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got rdy=%0b lid=%0d ps=%0b idx=%0d wt=%0d bi=%0d busy=%0b img=%0d err=%0b, expected all 0",
               pixel_i_ready, layer_id, pass_start, pass_idx, wt_base, bi_base, busy, img_cnt, err);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (pixel_i_ready !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_after_reset: got rdy=%0b busy=%0b, expected rdy=1 busy=0", pixel_i_ready, busy);
    end
  endtask

  task automatic test_nominal();
    logic done_wait;
    do_reset();
    auto_en = 1'b1;
    feed(784);
    n_cmp++;
    if (pixel_i_ready !== 1'b0) begin
      n_bad++; $display("FAIL ready_after_784: got %0b expected 0", pixel_i_ready);
    end
    done_wait = 1'b0;
    for (int i = 0; i < 3000 && !done_wait; i++) begin
      @(negedge clk);
      if (log_q.size() >= 14) done_wait = 1'b1;
    end
    repeat (50) @(negedge clk);
    n_cmp++;
    if (log_q.size() != 14) begin
      n_bad++; $display("FAIL pass_count: got %0d expected 14", log_q.size());
    end
    for (int i = 0; i < 14; i++) begin
      if (i < log_q.size()) begin
        n_cmp++;
        if (int'(log_q[i].lid) != exp_lid[i] || int'(log_q[i].idx) != exp_idx[i] ||
            int'(log_q[i].wt) != exp_wt[i] || int'(log_q[i].bi) != exp_bi[i]) begin
          n_bad++;
          $display("FAIL pass_%0d: got lid=%0d idx=%0d wt=%0d bi=%0d expected lid=%0d idx=%0d wt=%0d bi=%0d",
                   i, log_q[i].lid, log_q[i].idx, log_q[i].wt, log_q[i].bi,
                   exp_lid[i], exp_idx[i], exp_wt[i], exp_bi[i]);
        end
      end
    end
    n_cmp++;
    if (busy !== 1'b1 || layer_id !== 2'd3 || img_cnt !== 16'd0 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL wait_digit: got busy=%0b lid=%0d img=%0d err=%0b expected 1 3 0 0", busy, layer_id, img_cnt, err);
    end
    digit_o_valid = 1'b1;
    @(negedge clk);
    digit_o_valid = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++; $display("FAIL busy_in_done: got %0b expected 1", busy);
    end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || img_cnt !== 16'd1) begin
      n_bad++; $display("FAIL image_done: got busy=%0b img=%0d expected busy=0 img=1", busy, img_cnt);
    end
  endtask

  task automatic test_watchdog();
    feed(500);
    repeat (99) @(negedge clk);
    n_cmp++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      n_bad++; $display("FAIL wd_early: got err=%0b busy=%0b expected err=0 busy=1", err, busy);
    end
    @(negedge clk);
    n_cmp++;
    if (err !== 1'b1 || busy !== 1'b0 || pixel_i_ready !== 1'b1 || img_cnt !== 16'd1) begin
      n_bad++;
      $display("FAIL wd_abort: got err=%0b busy=%0b rdy=%0b img=%0d expected 1 0 1 1", err, busy, pixel_i_ready, img_cnt);
    end
  endtask

  task automatic test_drain();
    logic done_wait;
    do_reset();
    slow_rcv_cyc = 0;
    auto_en = 1'b1; slow_mode = 1'b1;
    feed(784);
    done_wait = 1'b0;
    for (int i = 0; i < 3000 && !done_wait; i++) begin
      @(negedge clk);
      if (log_q.size() >= 14) done_wait = 1'b1;
    end
    n_cmp++;
    if (log_q.size() != 14) begin
      n_bad++; $display("FAIL drain_pass_count: got %0d expected 14", log_q.size());
    end else begin
      n_cmp++;
      if (log_q[13].lid !== 2'd3 || log_q[13].wt !== 11'd1737 || log_q[13].bi !== 4'd13) begin
        n_bad++;
        $display("FAIL fc7_pass: got lid=%0d wt=%0d bi=%0d expected 3 1737 13", log_q[13].lid, log_q[13].wt, log_q[13].bi);
      end
      n_cmp++;
      if ((log_q[13].c - log_q[12].c) < 70 || log_q[13].c <= slow_rcv_cyc) begin
        n_bad++;
        $display("FAIL drain_gap: got fc7 start cycle %0d (fc6 p3 at %0d, last rcv at %0d) expected >= %0d and > %0d",
                 log_q[13].c, log_q[12].c, slow_rcv_cyc, log_q[12].c + 70, slow_rcv_cyc);
      end
    end
    auto_en = 1'b0; slow_mode = 1'b0;
  endtask

  task automatic check_issue(input string nm, input int idx, input int wt, input int bi);
    n_cmp++;
    if (pass_start !== 1'b1 || layer_id !== 2'd1 || int'(pass_idx) != idx ||
        int'(wt_base) != wt || int'(bi_base) != bi) begin
      n_bad++;
      $display("FAIL %s: got ps=%0b lid=%0d idx=%0d wt=%0d bi=%0d expected ps=1 lid=1 idx=%0d wt=%0d bi=%0d",
               nm, pass_start, layer_id, pass_idx, wt_base, bi_base, idx, wt, bi);
    end
  endtask

  task automatic check_quiet(input string nm);
    int seen;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (pass_start) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_bad++; $display("FAIL %s: got %0d pass_starts expected 0", nm, seen);
    end
  endtask

  task automatic test_outstanding_limit();
    logic got;
    do_reset();
    feed(784);
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    wait_pass(20, got);
    n_cmp++;
    if (!got) begin
      n_bad++; $display("FAIL conv4_first_start: got none expected pass_start within 20 cycles");
    end
    check_issue("conv4_p0", 0, 9, 1);
    pulse(1'b1, 1'b0);
    check_issue("conv4_p1", 1, 153, 2);
    pulse(1'b1, 1'b0);
    check_quiet("limit_hold");
    pulse(1'b0, 1'b1);
    check_issue("conv4_p2_after_rcv", 2, 297, 3);
    pulse(1'b1, 1'b1);
    check_issue("conv4_p3_simultaneous", 3, 441, 4);
    pulse(1'b1, 1'b0);
    check_quiet("limit_after_simultaneous");
    pulse(1'b0, 1'b1);
    check_issue("conv4_p4", 4, 585, 5);
    n_cmp++;
    if (err !== 1'b0) begin
      n_bad++; $display("FAIL err_before_underflow: got %0b expected 0", err);
    end
    pulse(1'b0, 1'b1);
    pulse(1'b0, 1'b1);
    pulse(1'b0, 1'b1);
    n_cmp++;
    if (err !== 1'b1) begin
      n_bad++; $display("FAIL rcv_underflow_err: got %0b expected 1", err);
    end
    pulse(1'b1, 1'b0);
    check_issue("conv4_p5", 5, 729, 6);
    pulse(1'b1, 1'b0);
    check_issue("conv4_p6", 6, 873, 7);
    pulse(1'b1, 1'b0);
    check_quiet("saturated_counter_hold");
  endtask

  task automatic test_async_reset();
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({pixel_i_ready, layer_id, pass_start, pass_idx, wt_base, bi_base, busy, err} !== '0) begin
      n_bad++;
      $display("FAIL async_reset: got rdy=%0b lid=%0d ps=%0b idx=%0d wt=%0d bi=%0d busy=%0b err=%0b expected all 0",
               pixel_i_ready, layer_id, pass_start, pass_idx, wt_base, bi_base, busy, err);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    pixel_i_valid = 1'b1;
    @(negedge clk);
    pixel_i_valid = 1'b0;
    n_cmp++;
    if (pass_start !== 1'b1 || layer_id !== 2'd0 || pass_idx !== 4'd0 || busy !== 1'b1 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL restart_conv2: got ps=%0b lid=%0d idx=%0d busy=%0b err=%0b expected 1 0 0 1 0",
               pass_start, layer_id, pass_idx, busy, err);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_watchdog();
    test_drain();
    test_outstanding_limit();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
